// File: rtl/fpu_arbiter_if.sv
// Request/response/FPU bus for fpu_arbiter; rsp_err exists only with FPU_ARB_TIMEOUT_EN.
// slave = the arbiter's view, master = the requesters/FPU/consumer side.
interface fpu_arbiter_if #(
  parameter int N   = 2,
  parameter int IDW = 1
);
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [5*N-1:0]    req_ctl;
  logic [32*N-1:0]   req_x1;
  logic [32*N-1:0]   req_x2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_data;
`ifdef FPU_ARB_TIMEOUT_EN
  logic              rsp_err;
`endif
  logic [4:0]        fpu_ctl;
  logic [31:0]       fpu_x1;
  logic [31:0]       fpu_x2;
  logic              fpu_en;
  logic [31:0]       fpu_y;
  logic              fpu_ready;

`ifdef FPU_ARB_TIMEOUT_EN
  modport slave (
    input  req_valid, req_ctl, req_x1, req_x2, rsp_ready, fpu_y, fpu_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, fpu_ctl, fpu_x1, fpu_x2, fpu_en
  );
  modport master (
    output req_valid, req_ctl, req_x1, req_x2, rsp_ready, fpu_y, fpu_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, fpu_ctl, fpu_x1, fpu_x2, fpu_en
  );
`else
  modport slave (
    input  req_valid, req_ctl, req_x1, req_x2, rsp_ready, fpu_y, fpu_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, fpu_ctl, fpu_x1, fpu_x2, fpu_en
  );
  modport master (
    output req_valid, req_ctl, req_x1, req_x2, rsp_ready, fpu_y, fpu_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, fpu_ctl, fpu_x1, fpu_x2, fpu_en
  );
`endif
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FPU among N requesters, one op at a time.
// Optional WAIT watchdog with rsp_err enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int N       = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic            found;
  logic [N-1:0]    ready_c;
  logic [5*N-1:0]  ctl_sh;
  logic [32*N-1:0] x1_sh;
  logic [32*N-1:0] x2_sh;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= 32'(N)) s = s - 32'(N);
    return s[IDW-1:0];
  endfunction

  // Cyclic search from rr_ptr; only offered to requesters while IDLE.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx     = '0;
    ready_c = '0;
    for (int k = 0; k < N; k++) begin
      idx = wrap_add(rr_ptr, 32'(k));
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    if (state == IDLE && found) ready_c = {{(N-1){1'b0}}, 1'b1} << pick;
    ctl_sh = bus.req_ctl >> (5 * pick);
    x1_sh  = bus.req_x1 >> (32 * pick);
    x2_sh  = bus.req_x2 >> (32 * pick);
  end

  assign bus.req_ready = ready_c;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_id       <= '0;
      bus.fpu_ctl  <= '0;
      bus.fpu_x1   <= '0;
      bus.fpu_x2   <= '0;
      bus.fpu_en   <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      bus.rsp_err  <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_id      <= pick;
            bus.fpu_ctl <= ctl_sh[4:0];
            bus.fpu_x1  <= x1_sh[31:0];
            bus.fpu_x2  <= x2_sh[31:0];
            bus.fpu_en  <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus.fpu_en <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          if (bus.fpu_ready) begin
            bus.rsp_data  <= bus.fpu_y;
            bus.rsp_id    <= gnt_id;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
`ifdef FPU_ARB_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // The FPU never answered: hand back an all-ones result flagged as an error.
            bus.rsp_data  <= 32'hFFFF_FFFF;
            bus.rsp_id    <= gnt_id;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            bus.rsp_err   <= 1'b0;
`endif
            rr_ptr        <= wrap_add(gnt_id, 32'd1);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
